// File: rtl/jacobi_pkg.sv
// Shared definitions for the Jacobi eigen-solver datapath: Q2.30 constants,
// default convergence threshold and the pivot-search FSM encoding.
package jacobi_pkg;

  localparam int W     = 32;
  localparam int IDX_W = 6;

  localparam logic [W-1:0] ONE         = 32'h4000_0000;
  localparam logic [W-1:0] EPS_DEFAULT = 32'h0000_0400;
  localparam logic [W-1:0] ABS_SAT_MAX = 32'h7FFF_FFFF;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SCAN,
    ST_FETCH_P,
    ST_FETCH_Q,
    ST_WAIT,
    ST_OFFER,
    ST_DONE
  } state_e;

endpackage

// File: rtl/jacobi_abs_sat.sv
// Combinational saturating absolute value: the most negative code maps to the
// largest positive code instead of wrapping back to itself.
module jacobi_abs_sat #(
  parameter int W = jacobi_pkg::W
) (
  input  logic [W-1:0] x_i,
  output logic [W-1:0] mag_o
);

  localparam logic [W-1:0] MIN_NEG = {1'b1, {(W-1){1'b0}}};
  localparam logic [W-1:0] MAX_POS = {1'b0, {(W-1){1'b1}}};

  always_comb begin
    if (x_i == MIN_NEG) begin
      mag_o = MAX_POS;
    end else if (x_i[W-1]) begin
      mag_o = (~x_i) + W'(1);
    end else begin
      mag_o = x_i;
    end
  end

endmodule

// File: rtl/jacobi_pivot_search.sv
// Scans the upper triangle of the working matrix for the largest |a_pq|, then
// fetches a_pp/a_qq and offers the pivot, or flags convergence below EPS.
module jacobi_pivot_search #(
  parameter int N     = 32,
  parameter int W     = jacobi_pkg::W,
  parameter int IDX_W = jacobi_pkg::IDX_W,
  parameter logic [W-1:0] EPS = W'(jacobi_pkg::EPS_DEFAULT)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  output logic             busy,
  output logic             mem_rd_en,
  output logic [IDX_W-1:0] mem_row,
  output logic [IDX_W-1:0] mem_col,
  input  logic [W-1:0]     mem_rd_data,
  output logic             piv_valid,
  input  logic             piv_ready,
  output logic [IDX_W-1:0] piv_row,
  output logic [IDX_W-1:0] piv_col,
  output logic [W-1:0]     piv_app,
  output logic [W-1:0]     piv_aqq,
  output logic [W-1:0]     piv_apq,
  output logic             converged
);

  import jacobi_pkg::*;

  localparam logic [IDX_W-1:0] LAST_Q = IDX_W'(N - 1);
  localparam logic [IDX_W-1:0] LAST_P = IDX_W'(N - 2);

  state_e           state_q;
  logic             busy_q, converged_q, piv_valid_q;
  logic [IDX_W-1:0] scan_p_q, scan_q_q;
  logic             dat_valid_q;
  logic [IDX_W-1:0] dat_p_q, dat_q_q;
  logic [IDX_W-1:0] last_row_q, last_col_q;
  logic [W-1:0]     best_mag_q, best_apq_q;
  logic [IDX_W-1:0] best_p_q, best_q_q;
  logic [IDX_W-1:0] piv_row_q, piv_col_q;
  logic [W-1:0]     piv_app_q, piv_aqq_q, piv_apq_q;

  logic [W-1:0]     rd_mag;
  logic             take;
  logic [W-1:0]     best_mag_d, best_apq_d;
  logic [IDX_W-1:0] best_p_d, best_q_d;

  jacobi_abs_sat #(.W(W)) u_abs (
    .x_i   (mem_rd_data),
    .mag_o (rd_mag)
  );

  // Strict compare keeps the first element in scan order on ties.
  always_comb begin
    take       = dat_valid_q && (rd_mag > best_mag_q);
    best_mag_d = take ? rd_mag      : best_mag_q;
    best_apq_d = take ? mem_rd_data : best_apq_q;
    best_p_d   = take ? dat_p_q     : best_p_q;
    best_q_d   = take ? dat_q_q     : best_q_q;
  end

  // FETCH_P overlaps the return of the last scan datum, so it addresses
  // through the bypassed best index.
  always_comb begin
    mem_rd_en = 1'b0;
    mem_row   = last_row_q;
    mem_col   = last_col_q;
    unique case (state_q)
      ST_SCAN: begin
        mem_rd_en = 1'b1;
        mem_row   = scan_p_q;
        mem_col   = scan_q_q;
      end
      ST_FETCH_P: begin
        mem_rd_en = 1'b1;
        mem_row   = best_p_d;
        mem_col   = best_p_d;
      end
      ST_FETCH_Q: begin
        mem_rd_en = 1'b1;
        mem_row   = best_q_q;
        mem_col   = best_q_q;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      busy_q      <= 1'b0;
      converged_q <= 1'b0;
      piv_valid_q <= 1'b0;
      scan_p_q    <= '0;
      scan_q_q    <= '0;
      dat_valid_q <= 1'b0;
      dat_p_q     <= '0;
      dat_q_q     <= '0;
      last_row_q  <= '0;
      last_col_q  <= '0;
      best_mag_q  <= '0;
      best_apq_q  <= '0;
      best_p_q    <= '0;
      best_q_q    <= '0;
      piv_row_q   <= '0;
      piv_col_q   <= '0;
      piv_app_q   <= '0;
      piv_aqq_q   <= '0;
      piv_apq_q   <= '0;
    end else begin
      last_row_q  <= mem_row;
      last_col_q  <= mem_col;
      dat_valid_q <= (state_q == ST_SCAN);
      dat_p_q     <= scan_p_q;
      dat_q_q     <= scan_q_q;
      best_mag_q  <= best_mag_d;
      best_apq_q  <= best_apq_d;
      best_p_q    <= best_p_d;
      best_q_q    <= best_q_d;

      unique case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q     <= ST_SCAN;
            busy_q      <= 1'b1;
            converged_q <= 1'b0;
            best_mag_q  <= '0;
            best_apq_q  <= '0;
            best_p_q    <= '0;
            best_q_q    <= IDX_W'(1);
            scan_p_q    <= '0;
            scan_q_q    <= IDX_W'(1);
          end
        end
        ST_SCAN: begin
          if (scan_q_q == LAST_Q) begin
            if (scan_p_q == LAST_P) begin
              state_q <= ST_FETCH_P;
            end else begin
              scan_p_q <= scan_p_q + IDX_W'(1);
              scan_q_q <= scan_p_q + IDX_W'(2);
            end
          end else begin
            scan_q_q <= scan_q_q + IDX_W'(1);
          end
        end
        ST_FETCH_P: state_q <= ST_FETCH_Q;
        ST_FETCH_Q: begin
          piv_app_q <= mem_rd_data;
          state_q   <= ST_WAIT;
        end
        ST_WAIT: begin
          piv_aqq_q <= mem_rd_data;
          piv_row_q <= best_p_q;
          piv_col_q <= best_q_q;
          piv_apq_q <= best_apq_q;
          state_q   <= (best_mag_q >= EPS) ? ST_OFFER : ST_DONE;
        end
        // First OFFER cycle only raises valid; ready is honoured once visible.
        ST_OFFER: begin
          if (!piv_valid_q) begin
            piv_valid_q <= 1'b1;
          end else if (piv_ready) begin
            piv_valid_q <= 1'b0;
            busy_q      <= 1'b0;
            state_q     <= ST_IDLE;
          end
        end
        ST_DONE: begin
          converged_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign converged = converged_q;
  assign piv_valid = piv_valid_q;
  assign piv_row   = piv_row_q;
  assign piv_col   = piv_col_q;
  assign piv_app   = piv_app_q;
  assign piv_aqq   = piv_aqq_q;
  assign piv_apq   = piv_apq_q;

endmodule

// File: tb/tb_jacobi_pivot_search.sv
// Bench for jacobi_pivot_search at N=4: directed and random matrices, a
// transaction-level pivot model and a per-cycle compare process.
module tb_jacobi_pivot_search;

  localparam int N = 4;
  localparam int M = N * (N - 1) / 2;
  localparam logic [31:0] EPS = 32'h0000_0400;
  localparam logic [31:0] ONE = 32'h4000_0000;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        piv_ready = 1'b0;
  logic        busy, mem_rd_en, piv_valid, converged;
  logic [5:0]  mem_row, mem_col, piv_row, piv_col;
  logic [31:0] mem_rd_data = 32'h0;
  logic [31:0] piv_app, piv_aqq, piv_apq;

  logic [31:0] mat [N][N];
  int          n_checks = 0;
  int          n_fail = 0;
  int          rd_total = 0;

  bit          chk_en = 1'b0;
  logic        exp_busy, exp_valid, exp_conv, exp_rd_en;
  logic [5:0]  exp_row, exp_col, ep_row, ep_col;
  logic [31:0] ep_app, ep_aqq, ep_apq;

  bit          m_conv;
  int          m_p, m_q;
  logic [31:0] m_mag;
  int          seq_row [M+2];
  int          seq_col [M+2];

  always #5 clk = ~clk;

  jacobi_pivot_search #(.N(N), .W(32), .IDX_W(6), .EPS(EPS)) dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .busy        (busy),
    .mem_rd_en   (mem_rd_en),
    .mem_row     (mem_row),
    .mem_col     (mem_col),
    .mem_rd_data (mem_rd_data),
    .piv_valid   (piv_valid),
    .piv_ready   (piv_ready),
    .piv_row     (piv_row),
    .piv_col     (piv_col),
    .piv_app     (piv_app),
    .piv_aqq     (piv_aqq),
    .piv_apq     (piv_apq),
    .converged   (converged)
  );

  // Synchronous-read memory with one cycle of latency.
  always @(posedge clk) begin
    if (mem_rd_en) begin
      mem_rd_data <= (mem_row < 6'(N) && mem_col < 6'(N)) ? mat[mem_row][mem_col] : 32'hxxxx_xxxx;
      rd_total    <= rd_total + 1;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_checks++;
    if (act !== want) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("piv_valid", 32'(piv_valid), 32'(exp_valid));
      chk("converged", 32'(converged), 32'(exp_conv));
      chk("mem_rd_en", 32'(mem_rd_en), 32'(exp_rd_en));
      if (exp_rd_en) begin
        chk("mem_row", 32'(mem_row), 32'(exp_row));
        chk("mem_col", 32'(mem_col), 32'(exp_col));
      end
      if (exp_valid) begin
        chk("piv_row", 32'(piv_row), 32'(ep_row));
        chk("piv_col", 32'(piv_col), 32'(ep_col));
        chk("piv_app", piv_app, ep_app);
        chk("piv_aqq", piv_aqq, ep_aqq);
        chk("piv_apq", piv_apq, ep_apq);
      end
    end
  end

  function automatic logic [31:0] mag_of(input logic [31:0] x);
    if (x == 32'h8000_0000) return 32'h7FFF_FFFF;
    return x[31] ? (32'd0 - x) : x;
  endfunction

  // Largest |a_pq| over p<q, first in row-major order wins ties.
  task automatic model();
    int k = 0;
    m_mag = 32'h0;
    m_p   = 0;
    m_q   = 1;
    for (int p = 0; p < N - 1; p++) begin
      for (int q = p + 1; q < N; q++) begin
        seq_row[k] = p;
        seq_col[k] = q;
        k++;
        if (mag_of(mat[p][q]) > m_mag) begin
          m_mag = mag_of(mat[p][q]);
          m_p   = p;
          m_q   = q;
        end
      end
    end
    seq_row[M]   = m_p;
    seq_col[M]   = m_p;
    seq_row[M+1] = m_q;
    seq_col[M+1] = m_q;
    m_conv = (m_mag < EPS);
  endtask

  task automatic fill_identity();
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        mat[i][j] = (i == j) ? ONE : 32'h0;
  endtask

  task automatic fill_random(input int mode);
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        if (i == j || mode == 0) mat[i][j] = $urandom;
        else if (mode == 1) begin
          mat[i][j] = 32'($urandom_range(0, 32'h0000_0800));
          if ($urandom_range(0, 1) == 1) mat[i][j] = 32'd0 - mat[i][j];
        end else mat[i][j] = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
      end
    end
  endtask

  task automatic start_pulse(output int base);
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    base      = rd_total;
    exp_busy  = 1'b1;
    exp_conv  = 1'b0;
    exp_valid = 1'b0;
  endtask

  // One full sweep; hold = cycles of ready low after valid, poke = start
  // asserted while the offer is pending.
  task automatic sweep(input int hold, input bit poke);
    int base;
    model();
    piv_ready = (hold == 0);
    start_pulse(base);
    for (int c = 0; c < M + 4; c++) begin
      exp_rd_en = (c < M + 2);
      if (c < M + 2) begin
        exp_row = 6'(seq_row[c]);
        exp_col = 6'(seq_col[c]);
      end
      @(posedge clk);
      #1;
    end
    chk("read_count_at_result", 32'(rd_total - base), 32'(M + 2));
    if (m_conv) begin
      exp_conv = 1'b1;
      exp_busy = 1'b0;
    end else begin
      exp_valid = 1'b1;
      ep_row = 6'(m_p);
      ep_col = 6'(m_q);
      ep_app = mat[m_p][m_p];
      ep_aqq = mat[m_q][m_q];
      ep_apq = mat[m_p][m_q];
      for (int h = 0; h < hold; h++) begin
        start = poke && (h == 2);
        @(posedge clk);
        #1;
      end
      start     = poke;
      piv_ready = 1'b1;
      @(posedge clk);
      #1;
      start     = 1'b0;
      piv_ready = 1'b0;
      exp_valid = 1'b0;
      exp_busy  = 1'b0;
    end
    piv_ready = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("read_count_total", 32'(rd_total - base), 32'(M + 2));
  endtask

  // Start a sweep, then hit reset at edge 3 of the scan.
  task automatic abort_sweep();
    int base;
    model();
    start_pulse(base);
    for (int c = 0; c < 3; c++) begin
      exp_rd_en = 1'b1;
      exp_row   = 6'(seq_row[c]);
      exp_col   = 6'(seq_col[c]);
      if (c == 2) reset = 1'b1;
      @(posedge clk);
      #1;
    end
    reset     = 1'b0;
    exp_busy  = 1'b0;
    exp_rd_en = 1'b0;
    exp_valid = 1'b0;
    exp_conv  = 1'b0;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    chk("read_count_abort", 32'(rd_total - base), 32'd3);
  endtask

  task automatic pin(input string name, input int act, input int want);
    chk(name, 32'(act), 32'(want));
  endtask

  initial begin
    fill_identity();
    repeat (3) @(posedge clk);
    #1;
    chk("reset_busy", 32'(busy), 32'd0);
    chk("reset_valid", 32'(piv_valid), 32'd0);
    chk("reset_conv", 32'(converged), 32'd0);
    chk("reset_rd_en", 32'(mem_rd_en), 32'd0);
    chk("reset_row", 32'(mem_row), 32'd0);
    chk("reset_apq", piv_apq, 32'd0);
    exp_busy = 1'b0; exp_valid = 1'b0; exp_conv = 1'b0; exp_rd_en = 1'b0;
    exp_row = '0; exp_col = '0;
    @(negedge clk);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Identity: nothing off-diagonal, sweep converges.
    fill_identity();
    sweep(0, 1'b0);
    pin("model_identity_conv", int'(m_conv), 1);

    // Dominant a_13 with distinct diagonal entries.
    fill_identity();
    for (int p = 0; p < N - 1; p++)
      for (int q = p + 1; q < N; q++) mat[p][q] = 32'h0000_1000;
    mat[1][3] = 32'h2000_0000; mat[1][1] = 32'h3000_0000; mat[3][3] = 32'h1000_0000;
    sweep(0, 1'b1);
    pin("model_a13_p", m_p, 1);
    pin("model_a13_q", m_q, 3);

    // Same matrix under backpressure, start poked while offering.
    sweep(5, 1'b1);

    // Negative element wins on magnitude.
    fill_identity();
    mat[0][2] = 32'hD000_0000; mat[1][2] = 32'h2000_0000;
    sweep(0, 1'b0);
    pin("model_neg_p", m_p, 0);
    pin("model_neg_q", m_q, 2);

    // Most negative code saturates and beats -0.75.
    mat[2][3] = 32'h8000_0000;
    sweep(1, 1'b0);
    pin("model_sat_q", m_q, 3);
    chk("model_sat_mag", m_mag, 32'h7FFF_FFFF);

    // Tie keeps the first in scan order.
    fill_identity();
    mat[0][1] = 32'h1000_0000; mat[2][3] = 32'h1000_0000;
    sweep(0, 1'b0);
    pin("model_tie_p", m_p, 0);
    pin("model_tie_q", m_q, 1);

    // EPS boundary: exactly EPS offers, EPS-1 converges.
    fill_identity();
    mat[1][2] = 32'h0000_0400;
    sweep(0, 1'b0);
    pin("model_eps_eq_conv", int'(m_conv), 0);
    mat[1][2] = 32'hFFFF_FC01;
    sweep(0, 1'b0);
    pin("model_eps_lt_conv", int'(m_conv), 1);

    // Reset mid-scan, then a fresh sweep.
    fill_random(0);
    abort_sweep();
    sweep(0, 1'b0);

    for (int t = 0; t < 24; t++) begin
      fill_random(t % 3);
      sweep(int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
